// File: rtl/accum_bank_pkg.sv
// Shared types and defaults for the accumulate-buffer banks behind the PE-to-buffer crossbar.
package accum_bank_pkg;

    localparam int unsigned SYS_NUM_DST = 4;
    localparam int unsigned ACC_DATA_W  = 32;
    localparam int unsigned PKT_INDEX_W = 16;
    localparam int unsigned PKT_DATA_W  = 32;

    typedef struct packed {
        logic                          valid;
        logic [PKT_INDEX_W-1:0]        index;
        logic signed [PKT_DATA_W-1:0]  data;
    } data_packet_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bank_state_t;

endpackage

// File: rtl/accum_rmw_pipe.sv
// Two-stage read-modify-write accumulator over the partial-sum memory, with B-to-A forwarding
// and a drain read/clear port.
module accum_rmw_pipe
    import accum_bank_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = ACC_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      acc_valid,
    input  logic [$clog2(DEPTH)-1:0]  acc_addr,
    input  logic [DATA_W-1:0]         acc_data,
    input  logic                      clr_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      a_valid,
    output logic                      b_valid
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] a_old;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] b_old;
    logic [DATA_W-1:0] b_sum;

    // B's sum is not in mem until the end of this cycle, so a same-address A takes it directly.
    assign b_sum   = b_old + b_data;
    assign a_old   = (b_valid && (b_addr == a_addr)) ? b_sum : mem[a_addr];
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_addr  <= '0;
            a_data  <= '0;
            b_valid <= 1'b0;
            b_addr  <= '0;
            b_data  <= '0;
            b_old   <= '0;
            mem     <= '{default: '0};
        end else begin
            a_valid <= acc_valid;
            if (acc_valid) begin
                a_addr <= acc_addr;
                a_data <= acc_data;
            end
            b_valid <= a_valid;
            if (a_valid) begin
                b_addr <= a_addr;
                b_data <= a_data;
                b_old  <= a_old;
            end
            // Drain only runs with the pipe empty, so the two write sources never collide.
            if (b_valid) begin
                mem[b_addr] <= b_sum;
            end else if (clr_en) begin
                mem[rd_addr] <= '0;
            end
        end
    end

endmodule

// File: rtl/accum_bank.sv
// Accumulate-buffer bank: routes crossbar packets into the RMW pipe and drains/clears all
// entries over a valid/ready stream on request.
module accum_bank
    import accum_bank_pkg::*;
#(
    parameter int unsigned BANK_ID = 0,
    parameter int unsigned NUM_DST = SYS_NUM_DST,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned DATA_W  = ACC_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  data_packet_t              in_packet,
    input  logic                      in_valid,
    input  logic                      drain_req,
    input  logic                      drain_ready,
    output logic                      drain_valid,
    output logic [$clog2(DEPTH)-1:0]  drain_addr,
    output logic [DATA_W-1:0]         drain_data,
    output logic                      drain_done,
    output logic                      accepting,
    output logic                      err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    bank_state_t       state_q;
    bank_state_t       state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              clr_en;
    logic [31:0]       idx_full;
    logic              misroute;
    logic              acc_valid;
    logic              pkt_bad;
    logic [ADDR_W-1:0] acc_addr;
    logic              a_valid;
    logic              b_valid;
    logic              unused_pkt_valid;

    // Index interleave: this bank owns index % NUM_DST == BANK_ID; DEPTH is a power of two.
    assign idx_full  = 32'(in_packet.index);
    assign misroute  = (idx_full % NUM_DST) != BANK_ID;
    assign acc_addr  = ADDR_W'(idx_full / NUM_DST);
    assign acc_valid = in_valid && (state_q == ACCUM) && !misroute;
    assign pkt_bad   = in_valid && ((state_q != ACCUM) || misroute);

    assign unused_pkt_valid = in_packet.valid ^ b_valid;

    accum_rmw_pipe #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .acc_valid (acc_valid),
        .acc_addr  (acc_addr),
        .acc_data  (DATA_W'(in_packet.data)),
        .clr_en    (clr_en),
        .rd_addr   (cnt_q),
        .rd_data   (drain_data),
        .a_valid   (a_valid),
        .b_valid   (b_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            accepting   <= 1'b1;
            drain_valid <= 1'b0;
            drain_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            accepting   <= (state_d == ACCUM);
            drain_valid <= (state_d == DRAIN);
            drain_done  <= (state_d == DONE);
            if (pkt_bad) begin
                err <= 1'b1;
            end
        end
    end

    // FLUSH leaves once A is empty: B's last write lands on that same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (drain_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!a_valid) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (drain_ready) begin
                    clr_en = 1'b1;
                    cnt_d  = cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign drain_addr = cnt_q;

endmodule
